// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// Module   : pc_fetch_unit_pkg
// Purpose  : Shared fetch-state encodings and parameter defaults for the
//            PC fetch unit and its watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

    localparam int          DEF_ADDR_W        = 16;
    localparam int          DEF_INSTR_W       = 16;
    localparam logic [15:0] DEF_RESET_PC      = 16'h0000;
    localparam int          DEF_FETCH_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_HOLD  = 2'b11
    } fetch_state_e;

endpackage : pc_fetch_unit_pkg

`default_nettype wire

// File: rtl/pc_fetch_unit_watchdog.sv
// ============================================================================
// Module   : fetch_watchdog
// Purpose  : Counts cycles spent waiting on instruction memory and pulses
//            expire_o when TIMEOUT cycles pass without an ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int               CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // WAIT->DRAIN keeps counting: the fetch is still outstanding.
    assign expire_o = active_i & ~ack_i & (cnt_q == LAST);

    always_comb begin
        cnt_d = '0;
        if (active_i && !ack_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : fetch_watchdog

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Architectural PC register, instruction-memory fetch handshake
//            and decode hand-off. Define PC_FETCH_TIMEOUT_EN to enable the
//            fetch watchdog (fetch_err pulse + automatic re-request).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W        = DEF_ADDR_W,
    parameter int                INSTR_W       = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC      = ADDR_W'(DEF_RESET_PC),
    parameter int                FETCH_TIMEOUT = DEF_FETCH_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  next_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready,
    output logic               fetch_err
);

    generate
        if (FETCH_TIMEOUT < 2) begin : g_bad_timeout
            $error("pc_fetch_unit: FETCH_TIMEOUT must be at least 2");
        end
    endgenerate

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic               w_timeout;

`ifdef PC_FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT (FETCH_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .active_i ((state_q == ST_WAIT) || (state_q == ST_DRAIN)),
        .ack_i    (imem_ack),
        .expire_o (w_timeout)
    );
    assign fetch_err = w_timeout;
`else
    assign w_timeout = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        imem_req   = 1'b0;
        if_valid   = 1'b0;
        unique case (state_q)
            ST_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else begin
                    imem_req = ~rst;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = (imem_ack || w_timeout) ? ST_REQ : ST_DRAIN;
                end else if (imem_ack) begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = pc_q;
                    state_d    = ST_HOLD;
                end else if (w_timeout) begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The stale response is swallowed here; pc already holds the target.
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack || w_timeout) begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if_valid = ~redirect;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = ST_REQ;
                end else if (id_ready) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign pc_out    = pc_q;
    assign imem_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

endmodule : pc_fetch_unit

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam int AW = 16;
    localparam int IW = 16;
`ifdef PC_FETCH_TIMEOUT_EN
    localparam int TMO       = 8;
    localparam int EXP_PULSE = 1;
    localparam int EXP_NREQ  = 2;
`else
    localparam int TMO       = 64;
    localparam int EXP_PULSE = 0;
    localparam int EXP_NREQ  = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] next_pc, redirect_pc, pc_out, imem_addr, if_pc;
    logic          redirect, imem_req, imem_ack, if_valid, id_ready, fetch_err;
    logic [IW-1:0] imem_rdata, if_instr;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .ADDR_W        (AW),
        .INSTR_W       (IW),
        .RESET_PC      (16'h0000),
        .FETCH_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_out      (pc_out),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .fetch_err   (fetch_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Instruction memory: one response per request after a chosen latency.
    int            ack_at  = -1;
    logic [IW-1:0] ack_data;
    int            lat_min = 1;
    int            lat_max = 1;
    bit            mem_mute = 1'b0;
    bit            fixed_en = 1'b0;
    logic [IW-1:0] fixed_data = '0;

    // Reference model: what the fetch unit has promised, not how it is built.
    logic [AW-1:0] m_pc, m_ipc;
    logic [IW-1:0] m_instr;
    bit            m_inflight, m_stale, m_have;
    int            m_wait;

    logic [AW-1:0] req_log[$];
    int            vld_cnt = 0;
    int            fe_cnt  = 0;
    bit            saw_dead = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_ipc = '0; m_instr = '0;
        m_inflight = 1'b0; m_stale = 1'b0; m_have = 1'b0; m_wait = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
        #1;
        check_val("rst_pc_out",   pc_out,    0);
        check_val("rst_imem_req", imem_req,  0);
        check_val("rst_if_valid", if_valid,  0);
        check_val("rst_if_instr", if_instr,  0);
        check_val("rst_if_pc",    if_pc,     0);
        check_val("rst_fetch_err", fetch_err, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc++;
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic step(input bit rd, input logic [AW-1:0] rpc, input bit rdy,
                        input logic [AW-1:0] npc, input bit stray);
        bit ack, tmo, exp_req;
        redirect = rd; redirect_pc = rpc; id_ready = rdy; next_pc = npc;
        ack = (ack_at == cyc) || (stray && !m_inflight);
        imem_ack   = ack;
        imem_rdata = (ack_at == cyc) ? ack_data : IW'($urandom);
        #1;
`ifdef PC_FETCH_TIMEOUT_EN
        tmo = m_inflight && !ack && (m_wait == TMO - 1);
`else
        tmo = 1'b0;
`endif
        exp_req = !m_inflight && !m_have && !rd;
        check_val("imem_req",  imem_req,  exp_req);
        check_val("pc_out",    pc_out,    m_pc);
        check_val("imem_addr", imem_addr, m_pc);
        check_val("if_valid",  if_valid,  m_have && !rd);
        check_val("if_instr",  if_instr,  m_instr);
        check_val("if_pc",     if_pc,     m_ipc);
        check_val("fetch_err", fetch_err, tmo);
        if (if_valid) vld_cnt++;
        if (fetch_err) fe_cnt++;
        if (if_valid && if_instr == 16'hDEAD) saw_dead = 1'b1;

        if (exp_req) begin
            req_log.push_back(m_pc);
            if (!mem_mute) begin
                ack_at   = cyc + int'($urandom_range(lat_max, lat_min));
                ack_data = fixed_en ? fixed_data : (m_pc ^ 16'h3C5A);
            end
        end

        if (m_inflight && !ack && !tmo) m_wait++;
        else                            m_wait = 0;

        if (rd) begin
            m_pc   = rpc;
            m_have = 1'b0;
            if (m_inflight) begin
                if (ack || tmo) begin m_inflight = 1'b0; m_stale = 1'b0; end
                else            m_stale = 1'b1;
            end
        end else if (exp_req) begin
            m_inflight = 1'b1; m_stale = 1'b0;
        end else if (m_inflight && ack) begin
            if (!m_stale) begin
                m_instr = imem_rdata; m_ipc = m_pc; m_have = 1'b1;
            end
            m_inflight = 1'b0; m_stale = 1'b0;
        end else if (m_inflight && tmo) begin
            m_inflight = 1'b0; m_stale = 1'b0;
        end else if (m_have && rdy) begin
            m_pc = npc; m_have = 1'b0;
        end

        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; next_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
        do_reset();

        // Back-to-back sequential fetch, zero-wait memory.
        fixed_en = 1'b1; fixed_data = 16'hA001; lat_min = 1; lat_max = 1;
        req_log.delete(); vld_cnt = 0;
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, m_pc + 16'd4, 1'b0);
        check_val("seq_nreq",   req_log.size(), 3);
        check_val("seq_addr0",  (req_log.size() > 0) ? req_log[0] : 16'hFFFF, 16'h0000);
        check_val("seq_addr1",  (req_log.size() > 1) ? req_log[1] : 16'hFFFF, 16'h0004);
        check_val("seq_addr2",  (req_log.size() > 2) ? req_log[2] : 16'hFFFF, 16'h0008);
        check_val("seq_pulses", vld_cnt, 3);

        // Decode stall while an instruction is held.
        step(1'b1, 16'h0010, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        req_log.delete();
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 16'h0014, 1'b0);
        check_val("stall_noreq", req_log.size(), 0);
        check_val("stall_ifpc",  if_pc, 16'h0010);
        step(1'b0, '0, 1'b1, 16'h0014, 1'b0);

        // Redirect while a fetch is outstanding: the late data must be discarded.
        step(1'b1, 16'h0040, 1'b0, '0, 1'b0);
        fixed_data = 16'hDEAD; lat_min = 3; lat_max = 3;
        step(1'b0, '0, 1'b1, '0, 1'b0);
        step(1'b1, 16'h0100, 1'b1, '0, 1'b0);
        step(1'b0, '0, 1'b1, '0, 1'b0);
        fixed_data = 16'hA001; lat_min = 1; lat_max = 1;
        step(1'b0, '0, 1'b1, '0, 1'b0);
        req_log.delete();
        step(1'b0, '0, 1'b1, '0, 1'b0);
        step(1'b0, '0, 1'b1, '0, 1'b0);
        check_val("drain_next_addr", (req_log.size() > 0) ? req_log[0] : 16'hFFFF, 16'h0100);
        check_val("drain_no_dead",   saw_dead, 0);

        // Redirect wins over a simultaneous decode accept.
        step(1'b1, 16'h0300, 1'b1, 16'h0500, 1'b0);
        check_val("hold_redir_pc", pc_out, 16'h0300);

        // Reset in the middle of WAIT, then a stale ack in the first REQ cycle.
        step(1'b1, 16'h0200, 1'b0, '0, 1'b0);
        lat_min = 3; lat_max = 3;
        step(1'b0, '0, 1'b1, '0, 1'b0);
        step(1'b0, '0, 1'b1, '0, 1'b0);
        do_reset();
        ack_at = cyc; ack_data = 16'hBEEF;
        fixed_en = 1'b0; lat_min = 1; lat_max = 1;
        req_log.delete();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, m_pc + 16'd4, 1'b0);
        check_val("rst_first_req", (req_log.size() > 0) ? req_log[0] : 16'hFFFF, 16'h0000);

        // Memory never answers.
        do_reset();
        mem_mute = 1'b1; fe_cnt = 0; req_log.delete();
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, '0, 1'b0);
        check_val("tmo_pulses", fe_cnt, EXP_PULSE);
        check_val("tmo_nreq",   req_log.size(), EXP_NREQ);
        check_val("tmo_same_addr", (req_log.size() > 0) ? req_log[req_log.size()-1] : 16'hFFFF, 16'h0000);
        mem_mute = 1'b0;
        if (m_inflight) begin
            ack_at = cyc; ack_data = 16'h1234;
        end

        // Randomized traffic.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            automatic bit            rd  = ($urandom_range(9, 0) == 0);
            automatic bit            rdy = ($urandom_range(9, 0) < 7);
            automatic bit            st  = ($urandom_range(19, 0) == 0);
            automatic logic [AW-1:0] npc = ($urandom_range(1, 0) == 0) ? m_pc + 16'd4 : AW'($urandom);
            step(rd, AW'($urandom), rdy, npc, st);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_pc_fetch_unit

`default_nettype wire
